// File: rtl/lcd_timing_pkg.sv
// Shared constants and types for the 480x272 RGB-LCD raster timing generator.
package lcd_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 480;
  localparam int unsigned H_FP_DEF     = 8;
  localparam int unsigned H_SYNC_DEF   = 4;
  localparam int unsigned H_BP_DEF     = 43;
  localparam int unsigned V_ACTIVE_DEF = 272;
  localparam int unsigned V_FP_DEF     = 8;
  localparam int unsigned V_SYNC_DEF   = 4;
  localparam int unsigned V_BP_DEF     = 12;
  localparam int unsigned X_W_DEF      = 10;
  localparam int unsigned Y_W_DEF      = 9;

  localparam int unsigned RGB_R_W = 5;
  localparam int unsigned RGB_G_W = 6;
  localparam int unsigned RGB_B_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // RGB565: red in [15:11], green in [10:5], blue in [4:0]
  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/lcd_axis_counter.sv
// One raster axis: wrapping position counter with active/sync/last decodes.
module lcd_axis_counter #(
  parameter int unsigned ACTIVE = 480,
  parameter int unsigned FP     = 8,
  parameter int unsigned SYNC   = 4,
  parameter int unsigned BP     = 43,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         active,
  output logic         sync,
  output logic         last
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

  assign active = (cnt < W'(ACTIVE));
  assign sync   = (cnt >= W'(SYNC_START)) && (cnt < W'(SYNC_END));
  assign last   = (cnt == W'(TOTAL - 1));

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB-LCD raster timing: run/drain FSM, one-cycle-early pixel requests and
// a two-stage pipeline that lines pixel data up with DE/HSYNC/VSYNC.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned X_W      = X_W_DEF,
  parameter int unsigned Y_W      = Y_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               pix_req,
  output logic [X_W-1:0]     px_x,
  output logic [Y_W-1:0]     px_y,
  output logic               frame_start,
  input  logic [15:0]        pix_rgb,
  output logic               lcd_de,
  output logic               lcd_hsync_n,
  output logic               lcd_vsync_n,
  output logic [RGB_R_W-1:0] lcd_r,
  output logic [RGB_G_W-1:0] lcd_g,
  output logic [RGB_B_W-1:0] lcd_b,
  output logic               busy
);

  state_t         state;
  logic [X_W-1:0] hc;
  logic [Y_W-1:0] vc;
  logic           h_active, h_sync, h_last;
  logic           v_active, v_sync, v_last;
  logic           run, frame_end, pix_on;
  logic           hs_d, vs_d;
  rgb565_t        rgb;

  assign run       = (state != IDLE);
  assign frame_end = h_last && v_last;
  assign pix_on    = run && h_active && v_active;
  assign rgb       = rgb565_t'(pix_rgb);

  lcd_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
  ) u_h (
    .clk(clk), .rst(rst), .clr(!run), .inc(run),
    .cnt(hc), .active(h_active), .sync(h_sync), .last(h_last)
  );

  lcd_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
  ) u_v (
    .clk(clk), .rst(rst), .clr(!run), .inc(h_last),
    .cnt(vc), .active(v_active), .sync(v_sync), .last(v_last)
  );

  // Frames only end at the raster wrap; busy mirrors "state != IDLE"
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en && frame_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!en) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (frame_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 (request + delayed syncs) and stage 2 (panel pins)
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_req     <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      lcd_de      <= 1'b0;
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
    end else begin
      pix_req     <= pix_on;
      px_x        <= pix_on ? hc : '0;
      px_y        <= pix_on ? vc : '0;
      frame_start <= pix_on && (hc == '0) && (vc == '0);
      hs_d        <= run && h_sync;
      vs_d        <= run && v_sync;
      lcd_de      <= pix_req;
      lcd_hsync_n <= !hs_d;
      lcd_vsync_n <= !vs_d;
      lcd_r       <= pix_req ? rgb.r : '0;
      lcd_g       <= pix_req ? rgb.g : '0;
      lcd_b       <= pix_req ? rgb.b : '0;
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a shrunken raster: raster-order scoreboard on
// the pixel path plus directed line/frame/drain/reset timing measurements.
module tb_lcd_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 2, HB = 3;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam logic [40:0] IDLE_VEC = {1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pix_req, frame_start, lcd_de, lcd_hsync_n, lcd_vsync_n, busy;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [15:0] pix_rgb;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;

  int errors = 0;
  int checks = 0;
  logic mon_on = 1'b0;

  // monitor state and statistics
  logic [15:0] sb[$];
  logic [15:0] e;
  int nx = 0, ny = 0, cyc = 0;
  logic p_req = 1'b0, p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1, p_busy = 1'b0;
  int t_de_rise = 0, t_de_fall = 0, t_hs_fall = 0, t_vs_fall = 0, t_fs = 0;
  int de_len = 0, de_period = 0, de_rises = 0, de_rises_frame = 0;
  int hs_gap = 0, hs_len = 0, hs_count = 0;
  int vs_len = 0, vs_off = 0;
  int fs_count = 0, fs_period = 0, bursts_frame = 0, pix_frame = 0, pix_cnt = 0;
  int busy_falls = 0, busy_off = 0;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X_W(10), .Y_W(9)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_req(pix_req), .px_x(px_x), .px_y(px_y), .frame_start(frame_start),
    .pix_rgb(pix_rgb),
    .lcd_de(lcd_de), .lcd_hsync_n(lcd_hsync_n), .lcd_vsync_n(lcd_vsync_n),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // upstream source: encoded coordinates when requested, garbage otherwise
  assign pix_rgb = pix_req ? {px_x[4:0], px_y[5:0], px_x[4:0]} : 16'hFFFF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [40:0] out_vec();
    return {pix_req, px_x, px_y, frame_start, lcd_de, lcd_hsync_n, lcd_vsync_n,
            lcd_r, lcd_g, lcd_b, busy};
  endfunction

  task automatic check_idle(input string tag);
    check(tag, 64'(out_vec()), 64'(IDLE_VEC));
  endtask

  task automatic wait_fs(input int target, input string tag);
    int n = 0;
    while (fs_count < target && n < 3 * FRAME) begin
      step();
      n++;
    end
    check(tag, 64'(fs_count >= target), 64'd1);
  endtask

  // per-cycle scoreboard and edge statistics, sampled on the falling edge
  always @(negedge clk) begin
    if (!mon_on) begin
      nx = 0; ny = 0; sb.delete();
      p_req = 1'b0; p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_busy = 1'b0;
    end else begin
      cyc++;
      check("de_align", 64'(lcd_de), 64'(p_req));
      if (lcd_de) begin
        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          check("rgb", 64'({lcd_r, lcd_g, lcd_b}), 64'(e));
        end
      end else begin
        check("rgb_blank", 64'({lcd_r, lcd_g, lcd_b}), 64'd0);
      end
      if (frame_start) begin
        if (fs_count > 0) begin
          fs_period = cyc - t_fs;
          bursts_frame = de_rises_frame;
          pix_frame = pix_cnt;
        end
        t_fs = cyc; fs_count++; de_rises_frame = 0; pix_cnt = 0;
      end
      if (pix_req) begin
        check("frame_start", 64'(frame_start), 64'(nx == 0 && ny == 0));
        check("px_x", 64'(px_x), 64'(nx));
        check("px_y", 64'(px_y), 64'(ny));
        sb.push_back({5'(nx), 6'(ny), 5'(nx)});
        pix_cnt++;
        nx++;
        if (nx == int'(HA)) begin
          nx = 0; ny++;
          if (ny == int'(VA)) ny = 0;
        end
      end else begin
        check("req_idle", 64'({frame_start, px_x, px_y}), 64'd0);
      end
      if (lcd_de && !p_de) begin
        de_rises++; de_rises_frame++;
        if (de_rises > 1) de_period = cyc - t_de_rise;
        t_de_rise = cyc;
      end
      if (!lcd_de && p_de) begin de_len = cyc - t_de_rise; t_de_fall = cyc; end
      if (!lcd_hsync_n && p_hs) begin hs_gap = cyc - t_de_fall; t_hs_fall = cyc; end
      if (lcd_hsync_n && !p_hs) begin hs_len = cyc - t_hs_fall; hs_count++; end
      if (!lcd_vsync_n && p_vs) begin vs_off = cyc - t_de_rise; t_vs_fall = cyc; end
      if (lcd_vsync_n && !p_vs) vs_len = cyc - t_vs_fall;
      if (!busy && p_busy) begin busy_falls++; busy_off = cyc - t_fs; end
      p_req = pix_req; p_de = lcd_de; p_hs = lcd_hsync_n; p_vs = lcd_vsync_n; p_busy = busy;
    end
  end

  initial begin
    int n;
    int bad;

    // reset and idle hold
    repeat (3) step();
    check_idle("reset_state");
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_vec() !== IDLE_VEC) bad++;
    end
    check("idle_hold", 64'(bad), 64'd0);

    // run: line and frame timing
    mon_on = 1'b1;
    en = 1'b1;
    wait_fs(1, "first_frame_timeout");
    check("busy_run", 64'(busy), 64'd1);
    n = 0;
    while (hs_count < 1 && n < 4 * HT) begin step(); n++; end
    check("de_len", 64'(de_len), 64'(HA));
    check("hs_gap", 64'(hs_gap), 64'(HF));
    check("hs_len", 64'(hs_len), 64'(HS));
    n = 0;
    while (de_rises < 2 && n < 4 * HT) begin step(); n++; end
    check("line_period", 64'(de_period), 64'(HT));
    wait_fs(3, "frame3_timeout");
    check("frame_period", 64'(fs_period), 64'(FRAME));
    check("de_bursts", 64'(bursts_frame), 64'(VA));
    check("pix_per_frame", 64'(pix_frame), 64'(HA * VA));
    check("vs_len", 64'(vs_len), 64'(VS * HT));
    check("vs_offset", 64'(vs_off), 64'((VF + 1) * HT));

    // en dropped then re-raised inside the frame: no gap
    wait_fs(4, "frame4_timeout");
    repeat (2 * HT) step();
    en = 1'b0;
    repeat (20) step();
    check("busy_drain", 64'(busy), 64'd1);
    en = 1'b1;
    wait_fs(5, "frame5_timeout");
    check("reraise_period", 64'(fs_period), 64'(FRAME));
    check("reraise_no_idle", 64'(busy_falls), 64'd0);

    // en dropped: frame completes, then idle
    repeat (2 * HT) step();
    en = 1'b0;
    n = 0;
    while (busy_falls < 1 && n < 2 * FRAME) begin step(); n++; end
    check("drain_busy_fall", 64'(busy_off), 64'(FRAME - 1));
    check("drain_bursts", 64'(de_rises_frame), 64'(VA));
    check("drain_pixels", 64'(pix_cnt), 64'(HA * VA));
    repeat (3) step();
    check_idle("drained_idle");
    repeat (20) step();
    check("no_new_frame", 64'(fs_count), 64'd5);

    // reset in the middle of an active line
    en = 1'b1;
    wait_fs(6, "frame6_timeout");
    n = 0;
    while (lcd_de !== 1'b1 && n < 2 * HT) begin step(); n++; end
    repeat (3) step();
    check("mid_line_de", 64'(lcd_de), 64'd1);
    mon_on = 1'b0;
    rst = 1'b1;
    step();
    check_idle("rst_mid_line");
    rst = 1'b0;
    step();
    mon_on = 1'b1;
    n = 0;
    while (pix_req !== 1'b1 && n < 50) begin step(); n++; end
    check("restart_first_req", 64'({pix_req, frame_start, px_x, px_y}),
          64'({1'b1, 1'b1, 10'd0, 9'd0}));
    repeat (2 * HT) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
